// File: rtl/mmcm_drp_sequencer.sv
// MMCME2_ADV DRP reconfiguration sequencer: holds the MMCM in reset,
// read-modify-writes an external register table, then waits for LOCKED.
module mmcm_drp_sequencer #(
    parameter int IDX_W        = 5,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [IDX_W-1:0] tbl_idx,
    input  logic [6:0]       tbl_addr,
    input  logic [15:0]      tbl_mask,
    input  logic [15:0]      tbl_data,
    input  logic             tbl_last,
    output logic [6:0]       daddr,
    output logic [15:0]      di,
    output logic             den,
    output logic             dwe,
    input  logic [15:0]      do_i,
    input  logic             drdy,
    output logic             mmcm_rst,
    input  logic             locked,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam int MAX_T = (DRDY_TIMEOUT > LOCK_TIMEOUT) ?
                           DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int CNT_W = $clog2(MAX_T);

    localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_MAX   = '1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_WR_WAIT,
        S_REL,
        S_LOCK_WAIT,
        S_FIN,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      rd_q, rd_d;
    logic             rst_q, rst_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            rst_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            rst_q   <= rst_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    // Timeout counter idles at zero, so every *_WAIT entry starts fresh.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = '0;
        rd_d    = rd_q;
        rst_d   = rst_q;
        busy_d  = busy_q;
        err_d   = err_q;
        code_d  = code_q;
        den     = 1'b0;
        dwe     = 1'b0;
        daddr   = '0;
        di      = '0;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (start) begin
                    state_d = S_RST;
                    rst_d   = 1'b1;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    code_d  = 2'b00;
                end
            end
            S_RST: begin
                state_d = S_RD;
            end
            S_RD: begin
                den     = 1'b1;
                daddr   = tbl_addr;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (drdy) begin
                    rd_d    = do_i;
                    state_d = S_WR;
                end else if (cnt_q == DRDY_LAST) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                    code_d  = 2'b01;
                    rst_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WR: begin
                den     = 1'b1;
                dwe     = 1'b1;
                daddr   = tbl_addr;
                di      = (rd_q & tbl_mask) | (tbl_data & ~tbl_mask);
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (drdy) begin
                    if (tbl_last || idx_q == IDX_MAX) begin
                        state_d = S_REL;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_RD;
                    end
                end else if (cnt_q == DRDY_LAST) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                    code_d  = 2'b01;
                    rst_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REL: begin
                rst_d   = 1'b0;
                state_d = S_LOCK_WAIT;
            end
            S_LOCK_WAIT: begin
                if (locked) begin
                    state_d = S_FIN;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                    code_d  = 2'b10;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_ERR: begin
                done    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tbl_idx  = idx_q;
    assign mmcm_rst = rst_q;
    assign busy     = busy_q;
    assign err      = err_q;
    assign err_code = code_q;

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Bench for mmcm_drp_sequencer: DRP slave model, table vectors,
// corner-case sequences and randomized tables against a reference model.
module tb_mmcm_drp_sequencer;

    localparam int IDX_W = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, start, tbl_last, drdy, locked;
    logic             den, dwe, mmcm_rst, busy, done, err;
    logic [IDX_W-1:0] tbl_idx;
    logic [6:0]       tbl_addr, daddr;
    logic [15:0]      tbl_mask, tbl_data, di, do_i;
    logic [1:0]       err_code;

    logic [6:0]  t_addr [4];
    logic [15:0] t_mask [4];
    logic [15:0] t_data [4];
    logic        t_last [4];

    assign tbl_addr = t_addr[tbl_idx];
    assign tbl_mask = t_mask[tbl_idx];
    assign tbl_data = t_data[tbl_idx];
    assign tbl_last = t_last[tbl_idx];

    mmcm_drp_sequencer #(
        .IDX_W(IDX_W),
        .DRDY_TIMEOUT(64),
        .LOCK_TIMEOUT(100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .tbl_idx(tbl_idx), .tbl_addr(tbl_addr),
        .tbl_mask(tbl_mask), .tbl_data(tbl_data),
        .tbl_last(tbl_last), .daddr(daddr), .di(di),
        .den(den), .dwe(dwe), .do_i(do_i), .drdy(drdy),
        .mmcm_rst(mmcm_rst), .locked(locked), .busy(busy),
        .done(done), .err(err), .err_code(err_code)
    );

    logic [15:0] mem [128];
    logic [15:0] mem_ref [128];
    logic [25:0] log_q [$];
    logic [25:0] exp_q [$];
    logic [15:0] resp;

    int nerr = 0, nchk = 0;
    int lat_cfg = 1, pend = 0, drop_rd = 0, rd_seen = 0;
    int bad_rst = 0, bsy_bad = 0;
    logic d_err, d_rst, e0;
    logic [1:0] d_code;

    typedef struct {
        logic [6:0]  addr;
        logic [15:0] mask;
        logic [15:0] data;
        logic [15:0] rdv;
        int          lat;
        logic [15:0] di;
        int          cyc;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock; the DRP slave acts on outputs seen at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        drdy = 1'b0;
        do_i = 16'($urandom);
        if (!rst_n) pend = 0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                drdy = 1'b1;
                do_i = resp;
            end
        end
        if (den === 1'b1) begin
            if (mmcm_rst !== 1'b1) bad_rst++;
            log_q.push_back({dwe, tbl_idx, daddr, dwe ? di : 16'h0});
            if (dwe) begin
                mem[daddr] = di;
                resp = 16'h0;
                pend = lat_cfg;
            end else begin
                rd_seen++;
                resp = mem[daddr];
                pend = (rd_seen == drop_rd) ? 0 : lat_cfg;
            end
        end
    endtask

    task automatic run_seq(output int lat, input int mid_k, input int lock_k);
        for (int a = 0; a < 128; a++) mem_ref[a] = mem[a];
        log_q.delete();
        rd_seen = 0;
        bad_rst = 0;
        bsy_bad = 0;
        lat = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        e0 = err;
        for (int k = 0; k < 400; k++) begin
            start = (k == mid_k);
            if (k == lock_k) locked = 1'b1;
            if (done) begin
                lat = k + 1;
                d_err = err;
                d_code = err_code;
                d_rst = mmcm_rst;
                break;
            end
            if (!busy) bsy_bad++;
            tick();
        end
        tick();
        start = 1'b0;
        chk("busy_after_done", 32'(busy), 0);
        chk("done_one_cycle", 32'(done), 0);
    endtask

    task automatic model(output int n);
        logic [15:0] v;
        logic [6:0]  a;
        exp_q.delete();
        n = 0;
        for (int i = 0; i < 4; i++) begin
            a = t_addr[i];
            v = (mem_ref[a] & t_mask[i]) | (t_data[i] & ~t_mask[i]);
            exp_q.push_back({1'b0, 2'(i), a, 16'h0});
            exp_q.push_back({1'b1, 2'(i), a, v});
            mem_ref[a] = v;
            n = i + 1;
            if (t_last[i]) break;
        end
    endtask

    task automatic check_run(string tag, int lat);
        int n;
        logic [25:0] act;
        model(n);
        chk({tag, "_ntx"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            act = (i < log_q.size()) ? log_q[i] : '1;
            chk($sformatf("%s_tx%0d", tag, i), 32'(act), 32'(exp_q[i]));
        end
        chk({tag, "_lat"}, lat, n * (2 + 2 * lat_cfg) + 4);
        chk({tag, "_err"}, {29'h0, d_err, d_code}, 0);
        chk({tag, "_rst_at_done"}, 32'(d_rst), 0);
        chk({tag, "_rst_during_drp"}, bad_rst, 0);
        chk({tag, "_busy"}, bsy_bad, 0);
        chk({tag, "_err_clr"}, 32'(e0), 0);
    endtask

    task automatic set3(logic [2:0] last_pat);
        for (int i = 0; i < 4; i++) begin
            t_addr[i] = 7'(8 + i);
            t_mask[i] = 16'hF00F;
            t_data[i] = 16'(16'h1230 + i * 16'h0110);
            t_last[i] = (i < 3) ? last_pat[i] : 1'b0;
        end
    endtask

    initial begin
        int lat, found;
        rst_n = 1'b0;
        start = 1'b0;
        drdy = 1'b0;
        do_i = '0;
        locked = 1'b1;
        for (int a = 0; a < 128; a++) mem[a] = 16'($urandom);
        set3(3'b100);
        repeat (3) tick();
        chk("reset_ctl", {24'h0, mmcm_rst, busy, done, err,
                          err_code, den, dwe, tbl_idx}, 0);
        chk("reset_drp", {daddr, di}, 0);
        rst_n = 1'b1;
        tick();

        vecs[0] = '{7'h08, 16'h1000, 16'h0145, 16'hFFFF, 1, 16'h1145, 8};
        vecs[1] = '{7'h28, 16'h00FF, 16'hAB00, 16'h1234, 1, 16'hAB34, 8};
        vecs[2] = '{7'h4E, 16'hFFFF, 16'h5555, 16'h0F0F, 2, 16'h0F0F, 10};
        vecs[3] = '{7'h7F, 16'h0000, 16'hBEEF, 16'h1234, 3, 16'hBEEF, 12};
        vecs[4] = '{7'h11, 16'hF0F0, 16'h1234, 16'hABCD, 64, 16'hA2C4, 134};
        for (int v = 0; v < 5; v++) begin
            t_addr[0] = vecs[v].addr;
            t_mask[0] = vecs[v].mask;
            t_data[0] = vecs[v].data;
            t_last[0] = 1'b1;
            mem[vecs[v].addr] = vecs[v].rdv;
            lat_cfg = vecs[v].lat;
            run_seq(lat, -1, -1);
            chk($sformatf("vec%0d_lat", v), lat, vecs[v].cyc);
            chk($sformatf("vec%0d_ntx", v), log_q.size(), 2);
            chk($sformatf("vec%0d_rd", v),
                32'((log_q.size() > 0) ? log_q[0] : '1),
                32'({1'b0, 2'd0, vecs[v].addr, 16'h0}));
            chk($sformatf("vec%0d_wr", v),
                32'((log_q.size() > 1) ? log_q[1] : '1),
                32'({1'b1, 2'd0, vecs[v].addr, vecs[v].di}));
            chk($sformatf("vec%0d_err", v), {29'h0, d_err, d_code}, 0);
            chk($sformatf("vec%0d_rst", v), 32'(d_rst | bad_rst[0]), 0);
        end

        set3(3'b100);
        lat_cfg = 3;
        run_seq(lat, -1, -1);
        check_run("three_lat3", lat);

        lat_cfg = 1;
        run_seq(lat, 5, -1);
        check_run("start_mid", lat);
        run_seq(lat, 15, -1);
        check_run("start_in_fin", lat);
        tick();
        chk("fin_start_dropped", 32'(busy), 0);

        drop_rd = 2;
        run_seq(lat, -1, -1);
        drop_rd = 0;
        chk("drdy_to_lat", lat, 71);
        chk("drdy_to_err", {29'h0, d_err, d_code}, 32'b101);
        chk("drdy_to_rst", 32'(d_rst), 0);
        repeat (3) tick();
        chk("err_sticky", {29'h0, err, err_code}, 32'b101);

        set3(3'b001);
        locked = 1'b0;
        run_seq(lat, -1, -1);
        chk("lock_to_lat", lat, 107);
        chk("lock_to_err", {29'h0, d_err, d_code}, 32'b110);
        chk("lock_to_rst", 32'(d_rst), 0);
        locked = 1'b1;
        run_seq(lat, -1, -1);
        check_run("lock_retry", lat);
        locked = 1'b0;
        run_seq(lat, -1, 105);
        chk("lock_edge_lat", lat, 107);
        chk("lock_edge_err", {29'h0, d_err, d_code}, 0);

        set3(3'b100);
        lat_cfg = 3;
        log_q.delete();
        found = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            foreach (log_q[i]) if (log_q[i][25]) found = 1;
            if (found == 0) tick();
        end
        chk("rst_saw_write", found, 1);
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        chk("midrst_ctl", {24'h0, mmcm_rst, busy, done, err,
                           err_code, den, dwe, tbl_idx}, 0);
        chk("midrst_drp", {daddr, di}, 0);
        rst_n = 1'b1;
        tick();
        run_seq(lat, -1, -1);
        check_run("after_rst", lat);

        set3(3'b000);
        lat_cfg = 1;
        run_seq(lat, -1, -1);
        check_run("no_last", lat);
        chk("no_last_idx3", 32'((log_q.size() == 8) ? log_q[7][24:23] : 2'd0), 3);

        for (int r = 0; r < 20; r++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++) begin
                t_addr[i] = 7'($urandom_range(0, 15));
                t_mask[i] = 16'($urandom);
                t_data[i] = 16'($urandom);
                t_last[i] = (i == n - 1) && ($urandom_range(0, 3) != 0);
            end
            for (int a = 0; a < 16; a++) mem[a] = 16'($urandom);
            lat_cfg = $urandom_range(1, 5);
            run_seq(lat, -1, -1);
            check_run($sformatf("rnd%0d", r), lat);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
